// File: rtl/stepdir_pkg.sv
// ---------------------------------------------------------------------------
// stepdir_pkg
// Shared widths and types for the step/dir receiver.
//   JOINT_W      : width of position and velocity readback
//   FILTER_CNT_W : width of the per-pin glitch-filter run counter
//   vel_state_e  : velocity-measurement FSM states
// ---------------------------------------------------------------------------
package stepdir_pkg;

   localparam int unsigned JOINT_W      = 32;
   localparam int unsigned FILTER_CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE,
      TRACK
   } vel_state_e;

endpackage

// File: rtl/pin_filter.sv
// ---------------------------------------------------------------------------
// pin_filter
// Two-flop synchronizer followed by a glitch filter for one asynchronous pin.
// The filtered level flips once FILTER_LEN consecutive synced samples differ
// from it; any sample equal to the current level restarts the count.
//
// Ports
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   din   : asynchronous pin
//   dout  : filtered level that the internal register takes at the next edge,
//           so a consumer registering its own copy sees the change at the
//           same edge the filter commits it
// ---------------------------------------------------------------------------
module pin_filter
   import stepdir_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam logic [FILTER_CNT_W-1:0] LenM1 = FILTER_CNT_W'(FILTER_LEN - 1);

   logic                    sync1_q;
   logic                    sync2_q;
   logic                    filt_q;
   logic                    filt_d;
   logic [FILTER_CNT_W-1:0] cnt_q;
   logic [FILTER_CNT_W-1:0] cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         // The current differing sample is the (cnt_q+1)-th in the run.
         if (cnt_q == LenM1) begin
            filt_d = ~filt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = filt_d;

endmodule

// File: rtl/stepdir_decoder.sv
// ---------------------------------------------------------------------------
// stepdir_decoder
// Step/dir receiver: filters the STP/DIR pins, counts signed position on
// filtered STP rising edges, flags DIR setup violations and measures the step
// period for a signed velocity readback.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   STP_in     : asynchronous step pin
//   DIR_in     : asynchronous direction pin, 1 = positive
//   clear      : zero position and clear dir_err (a same-cycle step still counts)
//   position   : signed step count, wraps modulo 2^32
//   velocity   : signed step period in clk cycles, 0 = stopped/unknown
//   step_pulse : one-cycle strobe per counted step
//   dir_err    : sticky DIR setup violation
// ---------------------------------------------------------------------------
module stepdir_decoder
   import stepdir_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 2,
   parameter int unsigned DIR_SETUP  = 4,
   parameter logic [31:0] TIMEOUT    = 32'd50_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               STP_in,
   input  logic               DIR_in,
   input  logic               clear,
   output logic [JOINT_W-1:0] position,
   output logic [JOINT_W-1:0] velocity,
   output logic               step_pulse,
   output logic               dir_err
);

   logic               stp_lvl;
   logic               dir_lvl;
   logic               stp_q;
   logic               dir_q;
   logic               step_ev;
   logic               dir_chg;
   logic               setup_viol;
   logic               timeout_hit;
   logic [31:0]        stab_q;
   logic [31:0]        stab_d;
   logic [31:0]        cnt_q;
   logic [31:0]        cnt_d;
   logic [31:0]        period;
   logic [JOINT_W-1:0] pos_q;
   logic [JOINT_W-1:0] pos_d;
   logic [JOINT_W-1:0] pos_base;
   logic [JOINT_W-1:0] vel_q;
   logic [JOINT_W-1:0] vel_d;
   logic               pulse_q;
   logic               err_q;
   logic               err_d;
   logic               dir_rec_q;
   logic               dir_rec_d;
   vel_state_e         state_q;
   vel_state_e         state_d;
   vel_state_e         state_eff;

   pin_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_stp_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (STP_in),
      .dout (stp_lvl)
   );

   pin_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_dir_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (DIR_in),
      .dout (dir_lvl)
   );

   // stp_q/dir_q hold the filtered levels; *_lvl is what they become next.
   assign step_ev = stp_lvl & ~stp_q;
   assign dir_chg = dir_lvl ^ dir_q;

   // stab_q+1 is the number of edges the filtered DIR has held, counting the
   // edge at which the step lands; a DIR flip at that same edge means zero.
   assign setup_viol = dir_chg | ((stab_q + 32'd1) < 32'(DIR_SETUP));

   always_comb begin
      stab_d = stab_q;
      if (dir_chg) begin
         stab_d = '0;
      end else if (stab_q < 32'(DIR_SETUP)) begin
         stab_d = stab_q + 32'd1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (step_ev) begin
         cnt_d = '0;
      end else if (cnt_q < TIMEOUT) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // The counter hits TIMEOUT at this edge unless a step zeroes it; the
   // timeout is applied first either way.
   assign timeout_hit = (state_q == TRACK) && (cnt_q == TIMEOUT - 32'd1);
   assign period      = cnt_q + 32'd1;

   always_comb begin
      pos_base = clear ? '0 : pos_q;
      pos_d    = pos_base;
      if (step_ev) begin
         pos_d = dir_lvl ? pos_base + 32'd1 : pos_base - 32'd1;
      end
   end

   always_comb begin
      err_d = err_q;
      if (step_ev && setup_viol) begin
         err_d = 1'b1;
      end else if (clear) begin
         err_d = 1'b0;
      end
   end

   always_comb begin
      state_eff = state_q;
      state_d   = state_q;
      dir_rec_d = dir_rec_q;
      vel_d     = vel_q;
      if (timeout_hit) begin
         vel_d     = '0;
         state_eff = IDLE;
         state_d   = IDLE;
      end
      if (step_ev) begin
         unique case (state_eff)
            IDLE: begin
               state_d   = TRACK;
               dir_rec_d = dir_lvl;
            end
            TRACK: begin
               if (dir_lvl == dir_rec_q) begin
                  vel_d = dir_lvl ? period : -period;
               end else begin
                  vel_d     = '0;
                  dir_rec_d = dir_lvl;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stp_q     <= 1'b0;
         dir_q     <= 1'b0;
         stab_q    <= '0;
         cnt_q     <= '0;
         pos_q     <= '0;
         vel_q     <= '0;
         pulse_q   <= 1'b0;
         err_q     <= 1'b0;
         dir_rec_q <= 1'b0;
         state_q   <= IDLE;
      end else begin
         stp_q     <= stp_lvl;
         dir_q     <= dir_lvl;
         stab_q    <= stab_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         vel_q     <= vel_d;
         pulse_q   <= step_ev;
         err_q     <= err_d;
         dir_rec_q <= dir_rec_d;
         state_q   <= state_d;
      end
   end

   assign position   = pos_q;
   assign velocity   = vel_q;
   assign step_pulse = pulse_q;
   assign dir_err    = err_q;

endmodule
